// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: assembles opcode + 0..2 operand bytes into a decode packet and
// injects reset/IRQ/NMI pseudo-packets at boundaries. Latency: len enabled cycles from opcode byte
// to fetch_valid. Backpressure: packet held in S_HOLD until fetch_ready; no bytes fetched meanwhile.
// Optional interrupt logic is built only when FETCH_INTR_EN is defined.
module fetch_sequencer #(
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 16'hFFFC,
    parameter logic [ADDR_W-1:0] NMI_VECTOR   = 16'hFFFA,
    parameter logic [ADDR_W-1:0] IRQ_VECTOR   = 16'hFFFE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_enable,
    input  logic [7:0]        data_in,
    input  logic              flush,
    input  logic              irq,
    input  logic              nmi,
    input  logic              irq_mask,
    output logic              pc_inc,
    output logic              fetch_valid,
    input  logic              fetch_ready,
    output logic [7:0]        fetch_opcode,
    output logic [ADDR_W-1:0] fetch_operand,
    output logic [1:0]        fetch_len,
    output logic [1:0]        fetch_intr
);

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_OPC   = 3'd1,
        S_LO    = 3'd2,
        S_HI    = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t     state;
    logic [1:0] op_len;
    logic       take_nmi;
    logic       take_irq;

    // 6502 instruction length from opcode bit groups b=op[4:2], cc=op[1:0]
    function automatic logic [1:0] decode_len(input logic [7:0] op);
        logic [2:0] b;
        logic [1:0] cc;
        b  = op[4:2];
        cc = op[1:0];
        if (op == 8'h20)
            return 2'd3;
        if (op == 8'h00 || op == 8'h40 || op == 8'h60)
            return 2'd1;
        case (b)
            3'd2:       return (cc == 2'b01) ? 2'd2 : 2'd1;
            3'd3, 3'd7: return 2'd3;
            3'd6:       return (cc == 2'b01) ? 2'd3 : 2'd1;
            default:    return 2'd2;
        endcase
    endfunction

    assign op_len = decode_len(data_in);

`ifdef FETCH_INTR_EN
    logic nmi_prev;
    logic nmi_pending;
    logic nmi_edge;

    assign nmi_edge = nmi & ~nmi_prev;
    assign take_nmi = (state == S_OPC) & nmi_pending;
    assign take_irq = (state == S_OPC) & ~nmi_pending & irq & ~irq_mask;

    // A new edge wins over the clear, so an NMI arriving as another is taken is not lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_prev    <= 1'b0;
            nmi_pending <= 1'b0;
        end else if (clk_enable) begin
            nmi_prev <= nmi;
            if (nmi_edge)
                nmi_pending <= 1'b1;
            else if (take_nmi && !flush)
                nmi_pending <= 1'b0;
        end
    end
`else
    logic unused_intr;

    assign unused_intr = ^{irq, nmi, irq_mask};
    assign take_nmi    = 1'b0;
    assign take_irq    = 1'b0;
`endif

    assign pc_inc = ((state == S_OPC) & ~take_nmi & ~take_irq) |
                    (state == S_LO) | (state == S_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_RESET;
            fetch_valid   <= 1'b0;
            fetch_opcode  <= 8'h00;
            fetch_operand <= '0;
            fetch_len     <= 2'd0;
            fetch_intr    <= 2'b00;
        end else if (clk_enable) begin
            if (flush && state != S_RESET) begin
                state       <= S_OPC;
                fetch_valid <= 1'b0;
            end else begin
                case (state)
                    S_RESET: begin
                        fetch_opcode  <= 8'h00;
                        fetch_operand <= RESET_VECTOR;
                        fetch_len     <= 2'd0;
                        fetch_intr    <= 2'b11;
                        fetch_valid   <= 1'b1;
                        state         <= S_HOLD;
                    end
                    S_OPC: begin
                        if (take_nmi) begin
                            fetch_opcode  <= 8'h00;
                            fetch_operand <= NMI_VECTOR;
                            fetch_len     <= 2'd0;
                            fetch_intr    <= 2'b10;
                            fetch_valid   <= 1'b1;
                            state         <= S_HOLD;
                        end else if (take_irq) begin
                            fetch_opcode  <= 8'h00;
                            fetch_operand <= IRQ_VECTOR;
                            fetch_len     <= 2'd0;
                            fetch_intr    <= 2'b01;
                            fetch_valid   <= 1'b1;
                            state         <= S_HOLD;
                        end else begin
                            fetch_opcode  <= data_in;
                            fetch_operand <= '0;
                            fetch_len     <= op_len;
                            fetch_intr    <= 2'b00;
                            if (op_len == 2'd1) begin
                                fetch_valid <= 1'b1;
                                state       <= S_HOLD;
                            end else begin
                                state <= S_LO;
                            end
                        end
                    end
                    S_LO: begin
                        fetch_operand <= {{(ADDR_W-8){1'b0}}, data_in};
                        if (fetch_len == 2'd2) begin
                            fetch_valid <= 1'b1;
                            state       <= S_HOLD;
                        end else begin
                            state <= S_HI;
                        end
                    end
                    S_HI: begin
                        fetch_operand[15:8] <= data_in;
                        fetch_valid         <= 1'b1;
                        state               <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (fetch_ready) begin
                            fetch_valid <= 1'b0;
                            state       <= S_OPC;
                        end
                    end
                    default: begin
                        fetch_valid <= 1'b0;
                        state       <= S_RESET;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; interrupt scenarios follow the FETCH_INTR_EN build option.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        clk_enable;
    logic [7:0]  data_in;
    logic        flush;
    logic        irq;
    logic        nmi;
    logic        irq_mask;
    logic        pc_inc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [7:0]  fetch_opcode;
    logic [15:0] fetch_operand;
    logic [1:0]  fetch_len;
    logic [1:0]  fetch_intr;

    int checks = 0;
    int errors = 0;
    int pc_cnt = 0;

    fetch_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_enable   (clk_enable),
        .data_in      (data_in),
        .flush        (flush),
        .irq          (irq),
        .nmi          (nmi),
        .irq_mask     (irq_mask),
        .pc_inc       (pc_inc),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .fetch_opcode (fetch_opcode),
        .fetch_operand(fetch_operand),
        .fetch_len    (fetch_len),
        .fetch_intr   (fetch_intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one byte for one enabled cycle, counting pc_inc pulses
    task automatic feed(input logic [7:0] b);
        data_in = b;
        #1;
        if (pc_inc === 1'b1) pc_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clk_enable = 1'b1; fetch_ready = 1'b1; data_in = 8'h00;
        flush = 1'b0; irq = 1'b0; nmi = 1'b0; irq_mask = 1'b0;
        #3;
        checks++;
        if ({fetch_valid, pc_inc, fetch_opcode, fetch_operand, fetch_len, fetch_intr} !== 30'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b pc=%b op=%h opd=%h len=%0d intr=%b, expected all zero",
                     fetch_valid, pc_inc, fetch_opcode, fetch_operand, fetch_len, fetch_intr);
        end
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (pc_inc !== 1'b0) begin
            errors++; $display("FAIL reset_pc_inc: got %b expected 0", pc_inc);
        end
        step();
        checks++;
        if ({fetch_valid, fetch_opcode, fetch_operand, fetch_len, fetch_intr} !== {1'b1, 8'h00, 16'hFFFC, 2'd0, 2'b11}) begin
            errors++;
            $display("FAIL reset_packet: got v=%b op=%h opd=%h len=%0d intr=%b, expected v=1 op=00 opd=fffc len=0 intr=11",
                     fetch_valid, fetch_opcode, fetch_operand, fetch_len, fetch_intr);
        end
        checks++;
        if (pc_inc !== 1'b0) begin
            errors++; $display("FAIL reset_hold_pc_inc: got %b expected 0", pc_inc);
        end
        step();
        checks++;
        if (fetch_valid !== 1'b0) begin
            errors++; $display("FAIL reset_transfer: valid got %b expected 0", fetch_valid);
        end
    endtask

    task automatic test_lda_abs();
        pc_cnt = 0;
        feed(8'hAD); feed(8'h34); feed(8'h12);
        checks++;
        if ({fetch_valid, fetch_opcode, fetch_operand, fetch_len, fetch_intr} !== {1'b1, 8'hAD, 16'h1234, 2'd3, 2'b00}) begin
            errors++;
            $display("FAIL lda_packet: got v=%b op=%h opd=%h len=%0d intr=%b, expected v=1 op=ad opd=1234 len=3 intr=00",
                     fetch_valid, fetch_opcode, fetch_operand, fetch_len, fetch_intr);
        end
        checks++;
        if (pc_cnt != 3) begin
            errors++; $display("FAIL lda_pc_inc_count: got %0d expected 3", pc_cnt);
        end
        step();
    endtask

    task automatic test_backpressure();
        fetch_ready = 1'b0;
        feed(8'hE8);
        data_in = 8'hA5;
        pc_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (pc_inc === 1'b1) pc_cnt++;
            checks++;
            if ({fetch_valid, fetch_opcode, fetch_len} !== {1'b1, 8'hE8, 2'd1}) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got v=%b op=%h len=%0d, expected v=1 op=e8 len=1",
                         i, fetch_valid, fetch_opcode, fetch_len);
            end
            step();
        end
        checks++;
        if (pc_cnt != 0) begin
            errors++; $display("FAIL hold_no_fetch: pc_inc pulses got %0d expected 0", pc_cnt);
        end
        fetch_ready = 1'b1;
        step();
        pc_cnt = 0;
        feed(8'hA5); feed(8'h10);
        checks++;
        if ({fetch_valid, fetch_opcode, fetch_operand, fetch_len} !== {1'b1, 8'hA5, 16'h0010, 2'd2}) begin
            errors++;
            $display("FAIL zp_packet: got v=%b op=%h opd=%h len=%0d, expected v=1 op=a5 opd=0010 len=2",
                     fetch_valid, fetch_opcode, fetch_operand, fetch_len);
        end
        checks++;
        if (pc_cnt != 2) begin
            errors++; $display("FAIL zp_pc_inc_count: got %0d expected 2", pc_cnt);
        end
        step();
    endtask

    task automatic test_interrupts();
`ifdef FETCH_INTR_EN
        feed(8'h8D);
        irq = 1'b1; irq_mask = 1'b0; nmi = 1'b1;
        feed(8'h00);
        nmi = 1'b0;
        feed(8'h02);
        checks++;
        if ({fetch_valid, fetch_opcode, fetch_operand, fetch_len, fetch_intr} !== {1'b1, 8'h8D, 16'h0200, 2'd3, 2'b00}) begin
            errors++;
            $display("FAIL sta_packet: got v=%b op=%h opd=%h len=%0d intr=%b, expected v=1 op=8d opd=0200 len=3 intr=00",
                     fetch_valid, fetch_opcode, fetch_operand, fetch_len, fetch_intr);
        end
        step();
        #1;
        checks++;
        if (pc_inc !== 1'b0) begin
            errors++; $display("FAIL nmi_pc_inc: got %b expected 0", pc_inc);
        end
        step();
        checks++;
        if ({fetch_valid, fetch_opcode, fetch_operand, fetch_len, fetch_intr} !== {1'b1, 8'h00, 16'hFFFA, 2'd0, 2'b10}) begin
            errors++;
            $display("FAIL nmi_packet: got v=%b op=%h opd=%h len=%0d intr=%b, expected v=1 op=00 opd=fffa len=0 intr=10",
                     fetch_valid, fetch_opcode, fetch_operand, fetch_len, fetch_intr);
        end
        step();
        step();
        checks++;
        if ({fetch_valid, fetch_opcode, fetch_operand, fetch_len, fetch_intr} !== {1'b1, 8'h00, 16'hFFFE, 2'd0, 2'b01}) begin
            errors++;
            $display("FAIL irq_packet: got v=%b op=%h opd=%h len=%0d intr=%b, expected v=1 op=00 opd=fffe len=0 intr=01",
                     fetch_valid, fetch_opcode, fetch_operand, fetch_len, fetch_intr);
        end
        irq = 1'b0;
        step();
`else
        irq = 1'b1; irq_mask = 1'b0; nmi = 1'b1;
        feed(8'hEA);
        nmi = 1'b0;
        checks++;
        if ({fetch_valid, fetch_opcode, fetch_len, fetch_intr} !== {1'b1, 8'hEA, 2'd1, 2'b00}) begin
            errors++;
            $display("FAIL intr_ignored: got v=%b op=%h len=%0d intr=%b, expected v=1 op=ea len=1 intr=00",
                     fetch_valid, fetch_opcode, fetch_len, fetch_intr);
        end
        step();
        feed(8'hE8);
        checks++;
        if ({fetch_valid, fetch_opcode, fetch_intr} !== {1'b1, 8'hE8, 2'b00}) begin
            errors++;
            $display("FAIL intr_ignored2: got v=%b op=%h intr=%b, expected v=1 op=e8 intr=00",
                     fetch_valid, fetch_opcode, fetch_intr);
        end
        irq = 1'b0;
        step();
`endif
    endtask

    task automatic test_irq_masked();
        irq = 1'b1; irq_mask = 1'b1;
        pc_cnt = 0;
        feed(8'hA5); feed(8'h10);
        checks++;
        if ({fetch_valid, fetch_opcode, fetch_operand, fetch_len, fetch_intr} !== {1'b1, 8'hA5, 16'h0010, 2'd2, 2'b00}) begin
            errors++;
            $display("FAIL irq_masked_packet: got v=%b op=%h opd=%h len=%0d intr=%b, expected v=1 op=a5 opd=0010 len=2 intr=00",
                     fetch_valid, fetch_opcode, fetch_operand, fetch_len, fetch_intr);
        end
        checks++;
        if (pc_cnt != 2) begin
            errors++; $display("FAIL irq_masked_pc_inc: got %0d expected 2", pc_cnt);
        end
        step();
        irq = 1'b0; irq_mask = 1'b0;
    endtask

    task automatic test_flush();
        feed(8'h4C);
        data_in = 8'h55;
        flush = 1'b1;
        #1;
        checks++;
        if (pc_inc !== 1'b1) begin
            errors++; $display("FAIL flush_pc_inc: got %b expected 1", pc_inc);
        end
        step();
        flush = 1'b0;
        clk_enable = 1'b0;
        data_in = 8'hEA;
        step(); step();
        checks++;
        if (fetch_valid !== 1'b0) begin
            errors++; $display("FAIL flush_no_packet: valid got %b expected 0", fetch_valid);
        end
        clk_enable = 1'b1;
        step();
        checks++;
        if ({fetch_valid, fetch_opcode, fetch_len} !== {1'b1, 8'hEA, 2'd1}) begin
            errors++;
            $display("FAIL flush_next: got v=%b op=%h len=%0d, expected v=1 op=ea len=1",
                     fetch_valid, fetch_opcode, fetch_len);
        end
        clk_enable = 1'b0;
        step(); step();
        checks++;
        if ({fetch_valid, fetch_opcode} !== {1'b1, 8'hEA}) begin
            errors++;
            $display("FAIL enable_hold: got v=%b op=%h, expected v=1 op=ea", fetch_valid, fetch_opcode);
        end
        clk_enable = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (fetch_valid !== 1'b0) begin
            errors++; $display("FAIL flush_hold: valid got %b expected 0", fetch_valid);
        end
        feed(8'hE8);
        checks++;
        if ({fetch_valid, fetch_opcode, fetch_len} !== {1'b1, 8'hE8, 2'd1}) begin
            errors++;
            $display("FAIL flush_hold_next: got v=%b op=%h len=%0d, expected v=1 op=e8 len=1",
                     fetch_valid, fetch_opcode, fetch_len);
        end
        step();
    endtask

    task automatic test_reset_mid_packet();
        feed(8'hAD);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fetch_valid, fetch_intr} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_clear: got v=%b intr=%b, expected v=0 intr=00", fetch_valid, fetch_intr);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({fetch_valid, fetch_operand, fetch_len, fetch_intr} !== {1'b1, 16'hFFFC, 2'd0, 2'b11}) begin
            errors++;
            $display("FAIL midreset_packet: got v=%b opd=%h len=%0d intr=%b, expected v=1 opd=fffc len=0 intr=11",
                     fetch_valid, fetch_operand, fetch_len, fetch_intr);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_lda_abs();
        test_backpressure();
        test_interrupts();
        test_irq_masked();
        test_flush();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
